// File: rtl/wb_pipe_reg_pkg.sv
// rtl/wb_pipe_reg_pkg.sv - shared constants and state encodings for the MEM/WB pipeline register
package wb_pipe_reg_pkg;

    localparam int WB_CH_DEF = 1;
    localparam int WB_AW_DEF = 5;
    localparam int WB_DW_DEF = 32;

    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;

    typedef logic [1:0] wb_state_t;

    // Encodings double as the entry count driven on the count port.
    localparam wb_state_t WB_EMPTY = 2'd0;
    localparam wb_state_t WB_ONE   = 2'd1;
    localparam wb_state_t WB_TWO   = 2'd2;

endpackage

// File: rtl/wb_pipe_reg_slot.sv
// rtl/wb_pipe_reg_slot.sv - CH-wide write-back payload register with load, clear and x0 suppression
module wb_slot
    import wb_pipe_reg_pkg::*;
#(
    parameter int CH = WB_CH_DEF,
    parameter int AW = WB_AW_DEF,
    parameter int DW = WB_DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [CH*AW-1:0] in_wd,
    input  logic [CH-1:0]    in_wreg,
    input  logic [CH*DW-1:0] in_wdata,
    output logic [CH*AW-1:0] wd,
    output logic [CH-1:0]    wreg,
    output logic [CH*DW-1:0] wdata
);

    logic [CH-1:0] wreg_gated;

    // Writes to x0 are dropped at capture so downstream never sees them enabled.
    for (genvar i = 0; i < CH; i++) begin : g_x0
        assign wreg_gated[i] = in_wreg[i] && (in_wd[i*AW +: AW] != AW'(NOPRegAddr));
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wd    <= {CH{AW'(NOPRegAddr)}};
            wreg  <= {CH{WriteDisable}};
            wdata <= {CH{DW'(ZeroWord)}};
        end else if (load) begin
            wd    <= in_wd;
            wreg  <= wreg_gated;
            wdata <= in_wdata;
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - MEM/WB pipeline register, valid/ready both sides; WB_SKID_EN adds a skid slot
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int CH = WB_CH_DEF,
    parameter int AW = WB_AW_DEF,
    parameter int DW = WB_DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*AW-1:0] in_wd,
    input  logic [CH-1:0]    in_wreg,
    input  logic [CH*DW-1:0] in_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*AW-1:0] out_wd,
    output logic [CH-1:0]    out_wreg,
    output logic [CH*DW-1:0] out_wdata,
    output logic [1:0]       count
);

    wb_state_t        state;
    wb_state_t        state_nx;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             main_clear;
    logic [CH*AW-1:0] main_wd;
    logic [CH-1:0]    main_wreg;
    logic [CH*DW-1:0] main_wdata;
    logic [CH*AW-1:0] src_wd;
    logic [CH-1:0]    src_wreg;
    logic [CH*DW-1:0] src_wdata;

    assign out_valid = (state != WB_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign count     = state;

`ifdef WB_SKID_EN
    logic             in_ready_q;
    logic             skid_load;
    logic [CH*AW-1:0] skid_wd;
    logic [CH-1:0]    skid_wreg;
    logic [CH*DW-1:0] skid_wdata;

    assign in_ready = in_ready_q;

    // Main refills from the skid slot when draining from TWO; otherwise from the input.
    assign src_wd    = (state == WB_TWO) ? skid_wd    : in_wd;
    assign src_wreg  = (state == WB_TWO) ? skid_wreg  : in_wreg;
    assign src_wdata = (state == WB_TWO) ? skid_wdata : in_wdata;

    always_comb begin
        state_nx   = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        if (flush) begin
            state_nx   = WB_EMPTY;
            main_clear = 1'b1;
        end else begin
            case (state)
                WB_EMPTY: begin
                    if (in_xfer) begin
                        state_nx  = WB_ONE;
                        main_load = 1'b1;
                    end
                end
                WB_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_nx  = WB_TWO;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_nx   = WB_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                WB_TWO: begin
                    if (out_xfer) begin
                        state_nx  = WB_ONE;
                        main_load = 1'b1;
                    end
                end
                default: begin
                    state_nx   = WB_EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    // Registered ready: derived from the next state, never from out_ready directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_nx != WB_TWO);
        end
    end

    wb_slot #(.CH(CH), .AW(AW), .DW(DW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (flush),
        .in_wd    (in_wd),
        .in_wreg  (in_wreg),
        .in_wdata (in_wdata),
        .wd       (skid_wd),
        .wreg     (skid_wreg),
        .wdata    (skid_wdata)
    );
`else
    assign in_ready  = !out_valid || out_ready;
    assign src_wd    = in_wd;
    assign src_wreg  = in_wreg;
    assign src_wdata = in_wdata;

    always_comb begin
        state_nx   = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            state_nx   = WB_EMPTY;
            main_clear = 1'b1;
        end else if (in_xfer) begin
            state_nx  = WB_ONE;
            main_load = 1'b1;
        end else if (out_xfer) begin
            state_nx   = WB_EMPTY;
            main_clear = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= WB_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    wb_slot #(.CH(CH), .AW(AW), .DW(DW)) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clear    (main_clear),
        .in_wd    (src_wd),
        .in_wreg  (src_wreg),
        .in_wdata (src_wdata),
        .wd       (main_wd),
        .wreg     (main_wreg),
        .wdata    (main_wdata)
    );

    assign out_wd    = main_wd;
    assign out_wreg  = main_wreg & {CH{out_valid}};
    assign out_wdata = main_wdata;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb/tb_wb_pipe_reg.sv - randomized and directed checks of wb_pipe_reg against a queue model
module tb_wb_pipe_reg;

    localparam int CH = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [CH*AW-1:0] wd;
        logic [CH-1:0]    wreg;
        logic [CH*DW-1:0] wdata;
    } bundle_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [CH*AW-1:0] in_wd;
    logic [CH-1:0]    in_wreg;
    logic [CH*DW-1:0] in_wdata;
    logic             out_valid;
    logic             out_ready;
    logic [CH*AW-1:0] out_wd;
    logic [CH-1:0]    out_wreg;
    logic [CH*DW-1:0] out_wdata;
    logic [1:0]       count;

    int errors = 0;
    int checks = 0;
    bundle_t q[$];

    always #5 clk = ~clk;

    wb_pipe_reg #(.CH(CH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wreg   (in_wreg),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wd    (out_wd),
        .out_wreg  (out_wreg),
        .out_wdata (out_wdata),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic cycle(input logic v, input logic f, input logic ordy,
                         input logic [CH*AW-1:0] wd, input logic [CH-1:0] wr,
                         input logic [CH*DW-1:0] wdat);
        bundle_t b;
        bundle_t head;
        logic    exp_ov;
        logic    exp_rdy;
        in_valid  = v;
        flush     = f;
        out_ready = ordy;
        in_wd     = wd;
        in_wreg   = wr;
        in_wdata  = wdat;
        #1;
        exp_ov = (q.size() != 0);
`ifdef WB_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || ordy;
`endif
        if (exp_ov) head = q[0];
        else        head = '0;
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("in_ready",  64'(in_ready),  64'(exp_rdy));
        check("count",     64'(count),     64'(q.size()));
        check("out_wd",    64'(out_wd),    64'(head.wd));
        check("out_wreg",  64'(out_wreg),  64'(head.wreg));
        check("out_wdata", 64'(out_wdata), 64'(head.wdata));
        b.wd    = wd;
        b.wdata = wdat;
        for (int c = 0; c < CH; c++) b.wreg[c] = wr[c] && (wd[c*AW +: AW] != 0);
        if (f) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [CH*AW-1:0] rwd;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_wd     = {5'd7, 5'd4};
        in_wreg   = 2'b11;
        in_wdata  = {32'h1234_5678, 32'h9ABC_DEF0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_wreg",  64'(out_wreg),  64'd0);
            check("rst_count",     64'(count),     64'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Streaming two bundles on channel 0.
        cycle(1, 0, 1, {5'd0, 5'd5}, 2'b01, {32'h0, 32'h11});
        cycle(1, 0, 1, {5'd0, 5'd6}, 2'b01, {32'h0, 32'h22});
        cycle(0, 0, 1, '0, '0, '0);
        cycle(0, 0, 1, '0, '0, '0);

        // Backpressure: A, B, then a third offer while stalled, then drain.
        cycle(1, 0, 0, {5'd1, 5'd2}, 2'b11, {32'hA1, 32'hA0});
        cycle(1, 0, 0, {5'd3, 5'd4}, 2'b11, {32'hB1, 32'hB0});
        cycle(1, 0, 0, {5'd5, 5'd6}, 2'b10, {32'hC1, 32'hC0});
        cycle(0, 0, 0, '0, '0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, '0, '0, '0);

        // x0 write suppressed on channel 0, channel 1 still writes.
        cycle(1, 0, 1, {5'd3, 5'd0}, 2'b11, {32'h0000_0033, 32'hDEAD_BEEF});
        cycle(0, 0, 1, '0, '0, '0);

        // Flush with a concurrent input while full (or stalled).
        cycle(1, 0, 0, {5'd9, 5'd8}, 2'b11, {32'hF1, 32'hF0});
        cycle(1, 0, 0, {5'd11, 5'd10}, 2'b11, {32'hF3, 32'hF2});
        cycle(1, 1, 0, {5'd13, 5'd12}, 2'b11, {32'hF5, 32'hF4});
        cycle(0, 0, 1, '0, '0, '0);
        cycle(0, 0, 1, '0, '0, '0);

        // Single entry stalled, then released.
        cycle(1, 0, 0, {5'd2, 5'd1}, 2'b11, {32'h77, 32'h66});
        cycle(1, 0, 0, {5'd4, 5'd3}, 2'b11, {32'h99, 32'h88});
        cycle(1, 0, 1, {5'd6, 5'd5}, 2'b11, {32'hBB, 32'hAA});
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, '0, '0, '0);

        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++)
                rwd[c*AW +: AW] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            cycle(1'($urandom_range(3) != 0),
                  1'($urandom_range(15) == 0),
                  1'($urandom_range(2) != 0),
                  rwd, 2'($urandom), {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised memory-to-writeback pipeline register for the RISC-V core, generalising the single-channel MEM/WB latch to CH write-back channels with configurable address/data widths. Replaces the stall-vector interface with a valid/ready handshake on both sides, plus a dedicated flush, and an optional 2-entry skid buffer so upstream `in_ready` is fully registered. Sits between the MEM stage and the register file write port(s).

## Interface
- `CH`, 1, number of parallel write-back channels
- `AW`, 5, register address width per channel
- `DW`, 32, write data width per channel
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `flush`  in  1  discard all held entries this cycle
- `in_valid`  in  1  MEM stage presents a bundle
- `in_ready`  out  1  block accepts a bundle this cycle
- `in_wd`  in  CH*AW  destination register per channel (channel i at [i*AW +: AW])
- `in_wreg`  in  CH  write enable per channel
- `in_wdata`  in  CH*DW  write data per channel
- `out_valid`  out  1  bundle available to writeback
- `out_ready`  in  1  writeback consumes bundle this cycle
- `out_wd`  out  CH*AW  destination register per channel
- `out_wreg`  out  CH  write enable per channel, already gated by `out_valid`
- `out_wdata`  out  CH*DW  write data per channel
- `count`  out  2  entries held (0..2)

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Capture rule: per channel, `wreg` is stored as 0 when `wd == 0` (x0 writes suppressed); `wd` and `wdata` are stored unchanged.
- Storage: main slot (drives outputs) and skid slot. States:
  - EMPTY (count 0): input transfer → ONE, main ← input.
  - ONE (count 1): input+output → ONE, main ← input; input only → TWO, skid ← input; output only → EMPTY; neither → ONE.
  - TWO (count 2): `in_ready` = 0; output → ONE, main ← skid; else hold.
- On any transition to EMPTY, the main payload is cleared: `wd` = 0, `wreg` = 0, `wdata` = 0.
- `out_wreg` is `main_wreg & out_valid`, so a register file may consume it without checking `out_valid`.
- Priority: reset > flush > normal. A flush drops the main and skid entries, forces EMPTY, and clears the payload. A bundle accepted in the flush cycle is discarded.
- Transfers are ignored while `rst` is low.

## Timing
- Latency: an input transfer in cycle N gives `out_valid` = 1 with that payload in cycle N+1.
- Throughput: one bundle per cycle while `out_ready` = 1.
- `in_ready` is registered and equals `count != 2`. It does not depend combinationally on `out_ready`.
- Reset values:
  - `out_valid` = 0, `out_wd` = 0, `out_wreg` = 0, `out_wdata` = 0.
  - `count` = 0, `in_ready` = 1.
  - Skid slot cleared.
- After a flush, the next cycle has `count` = 0, `out_valid` = 0 and `in_ready` = 1.
- Output payload is stable while `out_valid && !out_ready`. Order is strictly FIFO.

## Configuration
- `WB_SKID_EN` defined: 2-entry behaviour as above, with registered `in_ready`.
- `WB_SKID_EN` undefined:
  - No skid slot; states EMPTY/ONE only; `count` never exceeds 1.
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - All other rules unchanged: capture, x0 suppression, flush, reset, 1-cycle latency.

## Structure
- Shared defines file additions: `NOPRegAddr`, `ZeroWord`, `WriteDisable`, state encodings `WB_EMPTY`/`WB_ONE`/`WB_TWO`, and default widths.
- One sub-module, `wb_slot`: a CH-wide payload register with load, clear and x0-suppression. It is instantiated as main and skid; the skid instance exists only under `WB_SKID_EN`.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `in_valid` = 1 → `out_valid` = 0, `out_wreg` = 0, `count` = 0; first cycle after release `in_ready` = 1.
- Streaming: CH=2, bundles `{wd=5, wdata=0x11}` then `{wd=6, wdata=0x22}`, `out_ready` = 1 → each appears exactly 1 cycle after acceptance, `count` = 1.
- Backpressure (`WB_SKID_EN`): `out_ready` = 0, push A then B → `count` = 2, `in_ready` = 0, output holds A. Raise `out_ready` → A, then B, with no loss or duplication.
- x0 suppression: input `wd=0, wreg=1, wdata=0xDEADBEEF` → `out_wreg` = 0 on that channel; the other channel with `wd=3, wreg=1` still writes.
- Flush: with `count` = 2, assert `flush` together with `in_valid` → next cycle `count` = 0, `out_valid` = 0, outputs zeroed, and the flushed input never appears.
- No-skid build: `out_ready` = 0 while `count` = 1 → `in_ready` = 0 the same cycle; raising `out_ready` gives `in_ready` = 1 combinationally.
